// File: rtl/flag_unit_if.sv
// Bus between the ALU/decode side and the condition-flag unit.
// The master drives the instruction and pipeline controls and reads the flags.
// The slave (flag_unit) drives the committed/bypassed flags and the hazard request.
interface flag_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid_in;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] alu_result;
  logic             ovfl_in;
  logic             stall;
  logic             flush;
  logic [2:0]       F;
  logic [2:0]       F_fwd;
  logic             pend_valid;
  logic             hazard_stall;

  modport master (
    output valid_in, opcode, alu_result, ovfl_in, stall, flush,
    input  F, F_fwd, pend_valid, hazard_stall
  );

  modport slave (
    input  valid_in, opcode, alu_result, ovfl_in, stall, flush,
    output F, F_fwd, pend_valid, hazard_stall
  );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: captures ALU results, derives {Z,V,N} and commits them to the
// architectural flag register through a two-stage capture -> commit pipeline.
// Build option FLAG_FWD_EN: when defined, F_fwd bypasses the pending write and
// hazard_stall is 0; when undefined, F_fwd = F and hazard_stall = pend_valid.
module flag_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
  input logic        clk,
  input logic        rst_n,
  flag_unit_if.slave bus
);

  localparam int unsigned FLAG_W = 3;

  logic [FLAG_W-1:0] mask_c;
  logic [FLAG_W-1:0] flags_c;
  logic              accept_c;

  logic [FLAG_W-1:0] f_q;
  logic              pend_valid_q;
  logic [FLAG_W-1:0] pend_mask_q;
  logic [FLAG_W-1:0] pend_flags_q;

  // Per-opcode write mask, order {Z,V,N}.
  always_comb begin
    mask_c = 3'b000;
    unique case (bus.opcode)
      4'b0000, 4'b0001:          mask_c = 3'b111;
      4'b0010, 4'b0100,
      4'b0101, 4'b0110:          mask_c = 3'b100;
      default:                   mask_c = 3'b000;
    endcase
  end

  // Flag values of the presented instruction; a flush acts as no instruction.
  always_comb begin
    flags_c  = {~|bus.alu_result, bus.ovfl_in, bus.alu_result[WIDTH-1]};
    accept_c = bus.valid_in & ~bus.flush & (|mask_c);
  end

  // Capture stage and commit stage advance together unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q          <= RESET_FLAGS;
      pend_valid_q <= 1'b0;
      pend_mask_q  <= 3'b000;
      pend_flags_q <= 3'b000;
    end else if (!bus.stall) begin
      if (pend_valid_q) begin
        f_q <= (pend_mask_q & pend_flags_q) | (~pend_mask_q & f_q);
      end
      pend_valid_q <= accept_c;
      pend_mask_q  <= mask_c;
      pend_flags_q <= flags_c;
    end
  end

  assign bus.F          = f_q;
  assign bus.pend_valid = pend_valid_q;

`ifdef FLAG_FWD_EN
  // Decode sees the pending write merged over the committed flags.
  always_comb begin
    bus.F_fwd        = f_q;
    bus.hazard_stall = 1'b0;
    if (pend_valid_q) begin
      bus.F_fwd = (pend_mask_q & pend_flags_q) | (~pend_mask_q & f_q);
    end
  end
`else
  // No bypass: decode waits for the commit while a write is pending.
  always_comb begin
    bus.F_fwd        = f_q;
    bus.hazard_stall = pend_valid_q;
  end
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit; expectations hand-computed as {Z,V,N}.
module tb_flag_unit;

  localparam int unsigned WIDTH = 16;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  flag_unit_if #(.WIDTH(WIDTH)) bus ();

  flag_unit #(.WIDTH(WIDTH), .RESET_FLAGS(3'b000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] res,
                       input logic ov, input logic st, input logic fl);
    bus.valid_in   = v;
    bus.opcode     = op;
    bus.alu_result = res;
    bus.ovfl_in    = ov;
    bus.stall      = st;
    bus.flush      = fl;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] f, input logic pv,
                         input logic [2:0] fwd_on);
    chk({tag, "_F"}, {1'b0, bus.F}, {1'b0, f});
    chk({tag, "_pv"}, {3'b0, bus.pend_valid}, {3'b0, pv});
    chk({tag, "_fwd"}, {1'b0, bus.F_fwd}, {1'b0, FWD ? fwd_on : f});
    chk({tag, "_hs"}, {3'b0, bus.hazard_stall}, {3'b0, FWD ? 1'b0 : pv});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
    #12;
    chk_all("reset", 3'b000, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD result 0 with overflow -> Z=1 V=1 N=0
    drive(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("add_cap", 3'b000, 1'b1, 3'b110);
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("add_com", 3'b110, 1'b0, 3'b110);

    // XOR writes only Z
    drive(1'b1, 4'b0010, 16'h8000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("xor_cap", 3'b110, 1'b1, 3'b010);
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("xor_com", 3'b010, 1'b0, 3'b010);

    // SUB then 3 stalled cycles; stall beats flush and ignores a new valid
    drive(1'b1, 4'b0001, 16'h8001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 3'b010, 1'b1, 3'b001);
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("stall_rel", 3'b001, 1'b0, 3'b001);

    // Flushed ADD never captured
    drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("flush_cap", 3'b001, 1'b0, 3'b001);
    // ADD then flush of the next instruction: ADD still commits
    drive(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0001, 16'h0001, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("flush_next", 3'b100, 1'b0, 3'b100);

    // Non-writing opcodes: PADDSB and 4'b0011
    drive(1'b1, 4'b0111, 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("paddsb_cap", 3'b100, 1'b0, 3'b100);
    drive(1'b1, 4'b0011, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("op3_cap", 3'b100, 1'b0, 3'b100);

    // Back-to-back ADD (->011) then SUB (->100)
    drive(1'b1, 4'b0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("b2b_add", 3'b100, 1'b1, 3'b011);
    drive(1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("b2b_sub", 3'b011, 1'b1, 3'b100);
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("b2b_end", 3'b100, 1'b0, 3'b100);

    // SRA and ROR write Z only
    drive(1'b1, 4'b0101, 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0110, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("sra_com", 3'b000, 1'b1, 3'b100);
    drive(1'b1, 4'b0100, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("ror_com", 3'b100, 1'b1, 3'b000);

    // Async reset drops the pending SLL write immediately
    drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_reset", 3'b000, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 3'b000, 1'b0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
